// File: rtl/hms_timekeeper.sv
// hms_timekeeper: single-clock HH:MM:SS counter with a prescaled seconds tick and field-wise set mode.
// Alarm comparator and latch are built only when HMS_ALARM_EN is defined.
module hms_timekeeper #(
    parameter int TICK_DIV = 50000000,
    parameter int HOUR_MOD = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_run,
    input  logic       i_set,
    input  logic [1:0] i_field,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic [4:0] i_alarm_hour,
    input  logic [5:0] i_alarm_min,
    input  logic       i_alarm_en,
    input  logic       i_alarm_ack,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_tick,
    output logic       o_min_carry,
    output logic       o_hour_carry,
    output logic       o_day_carry,
    output logic       o_alarm
);

    localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [5:0]         MS_LAST    = 6'd59;
    localparam logic [5:0]         HOUR_LAST  = 6'(HOUR_MOD - 1);

    typedef enum logic [1:0] {
        MODE_HOLD,
        MODE_RUN,
        MODE_SET
    } mode_t;

    mode_t              mode;
    logic [PRESC_W-1:0] presc;
    logic               tick_now;
    logic               sec_wrap;
    logic               min_wrap;
    logic               hour_wrap;
    logic               step_req;
    logic [5:0]         sec_next;
    logic [5:0]         min_next;
    logic [4:0]         hour_next;

    function automatic logic [5:0] step_wrap(input logic [5:0] value,
                                             input logic [5:0] last,
                                             input logic       up);
        if (up)
            return (value == last) ? 6'd0 : value + 6'd1;
        else
            return (value == 6'd0) ? last : value - 6'd1;
    endfunction

    always_comb begin
        if (i_set)
            mode = MODE_SET;
        else if (i_run)
            mode = MODE_RUN;
        else
            mode = MODE_HOLD;
    end

    assign tick_now  = (mode == MODE_RUN) && (presc == PRESC_LAST);
    assign sec_wrap  = tick_now && (o_sec == MS_LAST);
    assign min_wrap  = sec_wrap && (o_min == MS_LAST);
    assign hour_wrap = min_wrap && ({1'b0, o_hour} == HOUR_LAST);
    assign step_req  = (mode == MODE_SET) && (i_inc ^ i_dec);

    always_comb begin
        sec_next  = o_sec;
        min_next  = o_min;
        hour_next = o_hour;
        if (tick_now) begin
            sec_next = sec_wrap ? 6'd0 : o_sec + 6'd1;
            if (sec_wrap)
                min_next = min_wrap ? 6'd0 : o_min + 6'd1;
            if (min_wrap)
                hour_next = hour_wrap ? 5'd0 : o_hour + 5'd1;
        end else if (step_req) begin
            // set-mode steps wrap inside the selected field only
            case (i_field)
                2'd0:    sec_next  = step_wrap(o_sec, MS_LAST, i_inc);
                2'd1:    min_next  = step_wrap(o_min, MS_LAST, i_inc);
                2'd2:    hour_next = 5'(step_wrap({1'b0, o_hour}, HOUR_LAST, i_inc));
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc        <= '0;
            o_sec        <= '0;
            o_min        <= '0;
            o_hour       <= '0;
            o_tick       <= 1'b0;
            o_min_carry  <= 1'b0;
            o_hour_carry <= 1'b0;
            o_day_carry  <= 1'b0;
        end else begin
            case (mode)
                MODE_RUN: presc <= tick_now ? '0 : presc + PRESC_ONE;
                MODE_SET: presc <= '0;
                default:  ;
            endcase
            o_sec        <= sec_next;
            o_min        <= min_next;
            o_hour       <= hour_next;
            o_tick       <= tick_now;
            o_min_carry  <= sec_wrap;
            o_hour_carry <= min_wrap;
            o_day_carry  <= hour_wrap;
        end
    end

`ifdef HMS_ALARM_EN
    logic alarm_match;

    // compare against the value being loaded so the latch rises with the matching tick
    assign alarm_match = tick_now && (sec_next == 6'd0) &&
                         (min_next == i_alarm_min) && (hour_next == i_alarm_hour);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_alarm <= 1'b0;
        else if (!i_alarm_en || i_alarm_ack)
            o_alarm <= 1'b0;
        else if (alarm_match)
            o_alarm <= 1'b1;
    end
`else
    logic alarm_unused;

    assign alarm_unused = ^{i_alarm_hour, i_alarm_min, i_alarm_en, i_alarm_ack};
    assign o_alarm      = 1'b0;
`endif

endmodule

// File: tb/tb_hms_timekeeper.sv
// Randomized and directed bench for hms_timekeeper against a seconds-of-day reference model.
// Expects o_alarm to follow the model only when HMS_ALARM_EN is defined.
module tb_hms_timekeeper;

    localparam int TICK_DIV = 4;
    localparam int HOUR_MOD = 24;
    localparam int DAY      = HOUR_MOD * 3600;
`ifdef HMS_ALARM_EN
    localparam bit ALARM_BUILT = 1'b1;
`else
    localparam bit ALARM_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       set_mode = 1'b0;
    logic [1:0] field = 2'd3;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic [4:0] alarm_hour = '0;
    logic [5:0] alarm_min = '0;
    logic       alarm_en = 1'b0;
    logic       alarm_ack = 1'b0;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       tick;
    logic       min_carry;
    logic       hour_carry;
    logic       day_carry;
    logic       alarm;

    int total = 0;
    int bad   = 0;

    // reference model: time as seconds-of-day, cycles counted since the last tick
    int m_t;
    int m_presc;
    bit m_alarm;
    bit m_tick, m_mc, m_hc, m_dc;

    hms_timekeeper #(.TICK_DIV(TICK_DIV), .HOUR_MOD(HOUR_MOD)) dut (
        .clk(clk), .rst(rst), .i_run(run), .i_set(set_mode), .i_field(field),
        .i_inc(inc), .i_dec(dec), .i_alarm_hour(alarm_hour), .i_alarm_min(alarm_min),
        .i_alarm_en(alarm_en), .i_alarm_ack(alarm_ack),
        .o_sec(sec), .o_min(min), .o_hour(hour), .o_tick(tick),
        .o_min_carry(min_carry), .o_hour_carry(hour_carry), .o_day_carry(day_carry),
        .o_alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_t = 0; m_presc = 0; m_alarm = 0;
        m_tick = 0; m_mc = 0; m_hc = 0; m_dc = 0;
    endfunction

    function automatic void model_edge();
        int s, m, h;
        bit hit;
        hit = 0;
        m_tick = 0; m_mc = 0; m_hc = 0; m_dc = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (set_mode) begin
            m_presc = 0;
            if (inc != dec && field != 2'd3) begin
                s = m_t % 60; m = (m_t / 60) % 60; h = m_t / 3600;
                case (field)
                    2'd0:    s = (s + (inc ? 1 : 59)) % 60;
                    2'd1:    m = (m + (inc ? 1 : 59)) % 60;
                    default: h = (h + (inc ? 1 : HOUR_MOD - 1)) % HOUR_MOD;
                endcase
                m_t = h * 3600 + m * 60 + s;
            end
        end else if (run) begin
            if (m_presc == TICK_DIV - 1) begin
                m_presc = 0;
                m_t = (m_t + 1) % DAY;
                m_tick = 1;
                m_mc = (m_t % 60 == 0);
                m_hc = (m_t % 3600 == 0);
                m_dc = (m_t == 0);
                hit = alarm_en && (m_t / 3600 == int'(alarm_hour)) &&
                      ((m_t / 60) % 60 == int'(alarm_min)) && (m_t % 60 == 0);
            end else begin
                m_presc++;
            end
        end
        if (!alarm_en || alarm_ack) m_alarm = 0;
        else if (hit) m_alarm = 1;
    endfunction

    task automatic check_all();
        check("sec", sec, m_t % 60);
        check("min", min, (m_t / 60) % 60);
        check("hour", hour, m_t / 3600);
        check("tick", tick, m_tick);
        check("min_carry", min_carry, m_mc);
        check("hour_carry", hour_carry, m_hc);
        check("day_carry", day_carry, m_dc);
        check("alarm", alarm, ALARM_BUILT ? m_alarm : 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // reset asserted and released between edges: outputs must clear without a clock
    task automatic async_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int ticks, mcs, all4, n;
        bit found;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;

        // free run: one tick every TICK_DIV cycles, minute carry on the 60th
        run = 1'b1;
        ticks = 0; mcs = 0;
        repeat (60 * TICK_DIV) begin
            cycle();
            if (tick) ticks++;
            if (tick && min_carry) mcs++;
        end
        check("ticks_in_240", ticks, 60);
        check("min_carry_count", mcs, 1);
        check("sec_after_60", sec, 0);
        check("min_after_60", min, 1);

        // preset 23:59:58 with wrapping decrements from zero
        async_reset();
        set_mode = 1'b1; run = 1'b0;
        field = 2'd2; dec = 1'b1; cycle(); dec = 1'b0; cycle();
        check("hour_dec_wrap", hour, HOUR_MOD - 1);
        check("hour_dec_no_carry", min_carry | hour_carry | day_carry, 0);
        field = 2'd1; dec = 1'b1; cycle();
        field = 2'd0; cycle(); cycle(); dec = 1'b0; cycle();
        check("preset_sec", sec, 58);
        set_mode = 1'b0; run = 1'b1;
        all4 = 0;
        repeat (2 * TICK_DIV) begin
            cycle();
            if (tick && min_carry && hour_carry && day_carry) all4++;
        end
        check("day_wrap_pulses", all4, 1);
        check("day_wrap_hour", hour, 0);

        // inc+dec together and field 3 are no-ops
        set_mode = 1'b1; field = 2'd1; inc = 1'b1; dec = 1'b1; cycle();
        dec = 1'b0; field = 2'd3; cycle();
        inc = 1'b0; cycle();
        check("noop_min", min, 0);

        // alarm 0:01 rises with the 60th tick, then ack clears it
        async_reset();
        set_mode = 1'b0; run = 1'b1;
        alarm_hour = 5'd0; alarm_min = 6'd1; alarm_en = 1'b1;
        repeat (60 * TICK_DIV) cycle();
        check("alarm_hit", alarm, ALARM_BUILT ? 1 : 0);
        alarm_ack = 1'b1; cycle(); alarm_ack = 1'b0; cycle();
        check("alarm_acked", alarm, 0);

        // ack on the matching edge wins
        async_reset();
        repeat (60 * TICK_DIV + 2) begin
            alarm_ack = (m_presc == TICK_DIV - 1) && (m_t == 59);
            cycle();
        end
        alarm_ack = 1'b0;
        check("alarm_ack_same_edge", alarm, 0);
        alarm_en = 1'b0;

        // reset at 0:00:37 with prescaler at 2, then first tick TICK_DIV cycles later
        async_reset();
        found = 0;
        for (int i = 0; i < 40 * TICK_DIV && !found; i++) begin
            cycle();
            if (m_t == 37 && m_presc == 2) found = 1;
        end
        check("reach_0_00_37", found, 1);
        async_reset();
        n = 0;
        do begin
            cycle();
            n++;
        end while (!tick && n < 4 * TICK_DIV);
        check("first_tick_latency", n, TICK_DIV);

        // random mix of modes, steps and alarm traffic
        for (int i = 0; i < 4000; i++) begin
            set_mode   = ($urandom % 8) == 0;
            run        = ($urandom % 6) != 0;
            field      = 2'($urandom % 4);
            inc        = ($urandom % 3) == 0;
            dec        = ($urandom % 3) == 0;
            alarm_hour = ($urandom % 4 == 0) ? 5'($urandom % 32) : 5'd0;
            alarm_min  = ($urandom % 4 == 0) ? 6'($urandom % 64) : 6'($urandom % 3);
            alarm_en   = ($urandom % 20) != 0;
            alarm_ack  = ($urandom % 40) == 0;
            if ($urandom % 700 == 0) async_reset();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
